// File: rtl/seg_pkg.sv
// Shared types and elaboration-time helpers for the noise-shaped coarse/fine segmentation stage.
package seg_pkg;

    typedef logic signed [31:0] wide_t;

    typedef enum logic [1:0] {
        ORD_FIRST  = 2'd1,
        ORD_SECOND = 2'd2
    } err_order_e;

    function automatic int v_width(input int in_w, input int order);
        return in_w + order + 2;
    endfunction

    function automatic int err_width(input int shift, input int order);
        return shift + order + 1;
    endfunction

    function automatic bit order_ok(input int order);
        return (order == int'(ORD_FIRST)) || (order == int'(ORD_SECOND));
    endfunction

    function automatic wide_t floor_shift(input wide_t x, input int sh);
        return x >>> sh;
    endfunction

    function automatic bit outside(input wide_t x, input wide_t lo, input wide_t hi);
        return (x < lo) || (x > hi);
    endfunction

    function automatic wide_t clamp(input wide_t x, input wide_t lo, input wide_t hi);
        if (x < lo)
            return lo;
        else if (x > hi)
            return hi;
        else
            return x;
    endfunction

endpackage

// File: rtl/seg_err_loop.sv
// Error-feedback loop: forms v from the held sample and past errors, quantises it to the
// coarse code and keeps the e1/e2 error history.
module seg_err_loop
    import seg_pkg::*;
#(
    parameter  int IN_W  = 5,
    parameter  int SHIFT = 1,
    parameter  int ORDER = 1,
    parameter  int B_W   = 6,
    parameter  int B_OFS = 9,
    localparam int V_W   = v_width(IN_W, ORDER)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [IN_W-1:0]  a_d,
    output logic [V_W-1:0]   coarse,
    output logic [V_W-1:0]   coarse_sh,
    output logic             clamped
);

    localparam int    ERR_W = err_width(SHIFT, ORDER);
    localparam wide_t Q_LO  = -wide_t'(B_OFS);
    localparam wide_t Q_HI  = wide_t'(2**B_W - 1 - B_OFS);
    localparam wide_t E_LO  = -(wide_t'(1) <<< (ERR_W - 1));
    localparam wide_t E_HI  = (wide_t'(1) <<< (ERR_W - 1)) - wide_t'(1);

    logic signed [ERR_W-1:0] e1;
    logic signed [ERR_W-1:0] e2;
    logic signed [V_W-1:0]   v;
    wide_t                   raw;
    wide_t                   q;
    wide_t                   e_full;

    // Residual is taken against the clamped coarse value, so a clamp shows up as a large error.
    always_comb begin
        if (ORDER == 2)
            v = V_W'($signed(a_d)) + (V_W'(e1) <<< 1) - V_W'(e2);
        else
            v = V_W'($signed(a_d)) + V_W'(e1);
        raw    = floor_shift(wide_t'(v), SHIFT);
        q      = clamp(raw, Q_LO, Q_HI);
        e_full = wide_t'(v) - (q <<< SHIFT);
    end

    assign coarse    = V_W'(q);
    assign coarse_sh = V_W'(q <<< SHIFT);
    assign clamped   = outside(raw, Q_LO, Q_HI) | outside(e_full, E_LO, E_HI);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            e1 <= '0;
            e2 <= '0;
        end else if (clr) begin
            e1 <= '0;
            e2 <= '0;
        end else if (en) begin
            e1 <= ERR_W'(clamp(e_full, E_LO, E_HI));
            e2 <= e1;
        end
    end

endmodule

// File: rtl/seg_shaped_splitter.sv
// Noise-shaped segmentation stage: splits each signed sample into offset coarse (B) and
// fine (C) codes for the unary DAC arrays, with valid hold, clamping and a sticky flag.
module seg_shaped_splitter
    import seg_pkg::*;
#(
    parameter int IN_W  = 5,
    parameter int SHIFT = 1,
    parameter int ORDER = 1,
    parameter int B_W   = 6,
    parameter int C_W   = 4,
    parameter int B_OFS = 9,
    parameter int C_OFS = 3
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  A,
    output logic             out_valid,
    output logic [B_W-1:0]   B,
    output logic [C_W-1:0]   C,
    output logic             sat
);

    localparam int    V_W  = v_width(IN_W, ORDER);
    localparam wide_t F_LO = -wide_t'(C_OFS);
    localparam wide_t F_HI = wide_t'(2**C_W - 1 - C_OFS);

    generate
        if (!order_ok(ORDER) || (SHIFT < 1) ||
            (B_OFS < 0) || (B_OFS > 2**B_W - 1) ||
            (C_OFS < 0) || (C_OFS > 2**C_W - 1)) begin : g_bad_params
            $fatal(1, "seg_shaped_splitter: illegal ORDER, SHIFT or offset parameter");
        end
    endgenerate

    logic [IN_W-1:0] a_d;
    logic            v1;
    logic            update;
    logic [V_W-1:0]  coarse;
    logic [V_W-1:0]  coarse_sh;
    logic            loop_clamped;
    wide_t           fine_raw;
    wide_t           fine_q;
    logic            fine_clamped;

    assign update = in_valid && v1 && !clr;

    seg_err_loop #(
        .IN_W  (IN_W),
        .SHIFT (SHIFT),
        .ORDER (ORDER),
        .B_W   (B_W),
        .B_OFS (B_OFS)
    ) u_err_loop (
        .clock     (clock),
        .rst       (rst),
        .clr       (clr),
        .en        (update),
        .a_d       (a_d),
        .coarse    (coarse),
        .coarse_sh (coarse_sh),
        .clamped   (loop_clamped)
    );

    // Fine code carries whatever the coarse array did not, so B and C rebuild a_d exactly.
    always_comb begin
        fine_raw     = wide_t'($signed(a_d)) - wide_t'($signed(coarse_sh));
        fine_q       = clamp(fine_raw, F_LO, F_HI);
        fine_clamped = outside(fine_raw, F_LO, F_HI);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            a_d       <= '0;
            v1        <= 1'b0;
            out_valid <= 1'b0;
            B         <= B_W'(B_OFS);
            C         <= C_W'(C_OFS);
            sat       <= 1'b0;
        end else if (clr) begin
            a_d       <= '0;
            v1        <= 1'b0;
            out_valid <= 1'b0;
            B         <= B_W'(B_OFS);
            C         <= C_W'(C_OFS);
            sat       <= 1'b0;
        end else if (in_valid) begin
            a_d <= A;
            v1  <= 1'b1;
            if (v1) begin
                B         <= B_W'(wide_t'($signed(coarse)) + wide_t'(B_OFS));
                C         <= C_W'(fine_q + wide_t'(C_OFS));
                out_valid <= 1'b1;
                sat       <= sat | loop_clamped | fine_clamped;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule
